psum_accum: RTL

PSUM_ACCUM -- requirements
Module: psum_accum

---
 rtl/psum_accum_pkg.sv | 18 +
 rtl/psum_accum_if.sv | 35 +++
 rtl/psum_accum_spad.sv | 26 ++
 rtl/psum_accum.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/psum_accum_pkg.sv
// rtl/psum_accum_pkg.sv - PECfg package: psum accumulator defaults, address type and FSM state enum
package PECfg;

  localparam int PROD_WD_DEF  = 8;
  localparam int PSUM_WD_DEF  = 16;
  localparam int PP_DEPTH_DEF = 16;
  localparam int PP_AWD_DEF   = $clog2(PP_DEPTH_DEF);

  typedef logic [PP_AWD_DEF-1:0] PsumAddr;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } PsumState;

endpackage

// File: rtl/psum_accum_if.sv
// rtl/psum_accum_if.sv - accumulate-beat, drain-request and psum-stream signal bundle
interface psum_accum_if
  import PECfg::*;
#(
  parameter int PROD_WD = PROD_WD_DEF,
  parameter int PSUM_WD = PSUM_WD_DEF,
  parameter int AWD     = PP_AWD_DEF
);
  logic               i_acc_valid;
  logic [PROD_WD-1:0] i_acc_prod;
  logic [AWD-1:0]     i_acc_addr;
  logic               i_acc_fstpix;
  logic               i_acc_sht;
  logic               o_acc_busy;
  logic               i_drain;
  logic [AWD:0]       i_drain_num;
  logic               o_psum_valid;
  logic               i_psum_busy;
  logic [PSUM_WD-1:0] o_psum;
  logic               o_done;

  // upstream / consumer side
  modport master (
    output i_acc_valid, i_acc_prod, i_acc_addr, i_acc_fstpix, i_acc_sht,
    output i_drain, i_drain_num, i_psum_busy,
    input  o_acc_busy, o_psum_valid, o_psum, o_done
  );

  // accumulator side
  modport slave (
    input  i_acc_valid, i_acc_prod, i_acc_addr, i_acc_fstpix, i_acc_sht,
    input  i_drain, i_drain_num, i_psum_busy,
    output o_acc_busy, o_psum_valid, o_psum, o_done
  );
endinterface

// File: rtl/psum_accum_spad.sv
// rtl/psum_accum_spad.sv - psum_spad: 1R1W psum register file, combinational read, synchronous write, no reset
module psum_spad
  import PECfg::*;
#(
  parameter int WD    = PSUM_WD_DEF,
  parameter int DEPTH = PP_DEPTH_DEF,
  parameter int AWD   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic [AWD-1:0] rd_addr,
  output logic [WD-1:0]  rd_data,
  input  logic           we,
  input  logic [AWD-1:0] wr_addr,
  input  logic [WD-1:0]  wr_data
);

  logic [WD-1:0] mem [DEPTH];

  assign rd_data = mem[rd_addr];

  // contents are only meaningful once written with a first-pixel beat
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

endmodule

// File: rtl/psum_accum.sv
// rtl/psum_accum.sv - partial-sum accumulator with RMW scratchpad and drain stream; PSUM_SAT_EN selects saturating arithmetic
module psum_accum
  import PECfg::*;
#(
  parameter int PROD_WD  = PROD_WD_DEF,
  parameter int PSUM_WD  = PSUM_WD_DEF,
  parameter int PP_DEPTH = PP_DEPTH_DEF
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  psum_accum_if.slave  bus
);

  localparam int AWD = $clog2(PP_DEPTH);

  PsumState           state, state_nxt;
  logic               drain_pend, drain_pend_nxt;
  logic               drain_take;
  logic               drain_fin;
  logic [AWD:0]       drain_num;
  logic [AWD:0]       rd_cnt;
  logic               wr_pend;
  logic [AWD-1:0]     wr_addr;
  logic [PSUM_WD-1:0] wr_data;
  logic [AWD-1:0]     rd_addr;
  logic [PSUM_WD-1:0] spad_rd;
  logic [PSUM_WD-1:0] old_val;
  logic [PSUM_WD-1:0] new_val;
  logic [PSUM_WD-1:0] psum_q;
  logic               psum_valid_q;
  logic               acc_busy;
  logic               accept;

  assign acc_busy = (state == ST_DRAIN) || (state == ST_DONE) || drain_pend;
  assign accept   = bus.i_acc_valid && !acc_busy;

  assign bus.o_acc_busy   = acc_busy;
  assign bus.o_psum_valid = psum_valid_q;
  assign bus.o_psum       = psum_q;
  assign bus.o_done       = (state == ST_DONE);

  // single read port: drain walks the counter, otherwise the beat address
  assign rd_addr = (state == ST_DRAIN) ? rd_cnt[AWD-1:0] : bus.i_acc_addr;
  assign old_val = (wr_pend && (wr_addr == rd_addr)) ? wr_data : spad_rd;

  psum_spad #(
    .WD    (PSUM_WD),
    .DEPTH (PP_DEPTH),
    .AWD   (AWD)
  ) u_spad (
    .clk     (i_clk),
    .rd_addr (rd_addr),
    .rd_data (spad_rd),
    .we      (wr_pend),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

`ifdef PSUM_SAT_EN
  localparam logic signed [PSUM_WD+1:0] MAX_W = {3'b000, {(PSUM_WD-1){1'b1}}};
  localparam logic signed [PSUM_WD+1:0] MIN_W = {3'b111, {(PSUM_WD-1){1'b0}}};

  function automatic logic [PSUM_WD-1:0] sat(input logic signed [PSUM_WD+1:0] v);
    if (v > MAX_W)      sat = MAX_W[PSUM_WD-1:0];
    else if (v < MIN_W) sat = MIN_W[PSUM_WD-1:0];
    else                sat = v[PSUM_WD-1:0];
  endfunction

  logic signed [PSUM_WD+1:0] shl_w, base_w, prod_w, sum_w;
  logic [PSUM_WD-1:0]        base;

  // shift and add each clamp to the signed psum range
  always_comb begin
    shl_w  = {old_val[PSUM_WD-1], old_val, 1'b0};
    base   = bus.i_acc_fstpix ? '0 : (bus.i_acc_sht ? sat(shl_w) : old_val);
    base_w = {{2{base[PSUM_WD-1]}}, base};
    prod_w = {{(PSUM_WD+2-PROD_WD){bus.i_acc_prod[PROD_WD-1]}}, bus.i_acc_prod};
    sum_w  = base_w + prod_w;
    new_val = sat(sum_w);
  end
`else
  logic [PSUM_WD-1:0] base, prod_x;

  // two's-complement wrap on both shift and add
  always_comb begin
    prod_x  = {{(PSUM_WD-PROD_WD){bus.i_acc_prod[PROD_WD-1]}}, bus.i_acc_prod};
    base    = bus.i_acc_fstpix ? '0 :
              (bus.i_acc_sht ? {old_val[PSUM_WD-2:0], 1'b0} : old_val);
    new_val = base + prod_x;
  end
`endif

  // pending write register: the accepted beat's result lands in the pad one cycle later
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_pend <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_pend <= accept;
      if (accept) begin
        wr_addr <= bus.i_acc_addr;
        wr_data <= new_val;
      end
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state      <= ST_IDLE;
      drain_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      drain_pend <= drain_pend_nxt;
    end
  end

  // drain is finished once every entry was loaded and the last one has left
  assign drain_fin = (rd_cnt == drain_num) && (!psum_valid_q || !bus.i_psum_busy);

  // next-state: a drain that collides with an accepted beat waits one cycle for its write
  always_comb begin
    state_nxt      = state;
    drain_pend_nxt = drain_pend;
    drain_take     = 1'b0;
    case (state)
      ST_IDLE, ST_ACC: begin
        if (drain_pend) begin
          state_nxt      = ST_DRAIN;
          drain_pend_nxt = 1'b0;
        end else if (bus.i_drain) begin
          drain_take = 1'b1;
          if (accept) begin
            drain_pend_nxt = 1'b1;
            state_nxt      = ST_ACC;
          end else begin
            state_nxt = ST_DRAIN;
          end
        end else if (accept) begin
          state_nxt = ST_ACC;
        end else if ((state == ST_ACC) && !wr_pend) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: if (drain_fin) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // drain datapath: registered output, advances only when the slot is free or taken
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      drain_num    <= '0;
      rd_cnt       <= '0;
      psum_q       <= '0;
      psum_valid_q <= 1'b0;
    end else if (state == ST_DRAIN) begin
      if (!psum_valid_q || !bus.i_psum_busy) begin
        if (rd_cnt < drain_num) begin
          psum_q       <= old_val;
          psum_valid_q <= 1'b1;
          rd_cnt       <= rd_cnt + 1'b1;
        end else begin
          psum_valid_q <= 1'b0;
        end
      end
    end else begin
      rd_cnt       <= '0;
      psum_valid_q <= 1'b0;
      if (drain_take) drain_num <= bus.i_drain_num;
    end
  end

endmodule
